// File: rtl/slc3_io_pkg.sv
// Shared types and defaults for the SLC-3 input conditioning front end.
package slc3_io_pkg;

  typedef enum logic {DB_STABLE, DB_PENDING} db_state_t;

  // 1 ms at 50 MHz.
  localparam int DB_CYCLES_DEFAULT = 50000;

endpackage

// File: rtl/slc3_input_conditioner_debounce_bit.sv
// One conditioning channel: 2-FF synchronizer, then a STABLE/PENDING debounce
// FSM. A new level is accepted only after it has disagreed with the current
// level for DB_CYCLES+1 consecutive synchronized cycles. rise/fall pulse for
// exactly the cycle in which the accepted level first shows the new value.
module debounce_bit
  import slc3_io_pkg::*;
#(
  parameter int   DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter logic RST_VAL   = 1'b0
) (
  input  logic Clk,
  input  logic Reset,
  input  logic in_raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int               CNT_W   = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES);

  logic             meta_q, sync_q;
  db_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_q, db_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // Two-flop synchronizer; resets to the idle level so no edge is seen at reset.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= in_raw;
      sync_q <= meta_q;
    end
  end

  // Debounce state, counter, accepted level and edge pulses.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= DB_STABLE;
      cnt_q   <= '0;
      db_q    <= RST_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Next-state: any agreement with the accepted level during PENDING abandons
  // the candidate, so a bounce restarts the count on the next disagreement.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      DB_STABLE: begin
        if (sync_q != db_q) begin
          state_d = DB_PENDING;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      DB_PENDING: begin
        if (sync_q == db_q) begin
          state_d = DB_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = DB_STABLE;
          cnt_d   = '0;
          db_d    = sync_q;
          rise_d  = sync_q;
          fall_d  = ~sync_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = DB_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign level = db_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/slc3_input_conditioner.sv
// SLC-3 board input front end: synchronizes and debounces the Run/Continue
// buttons (active-low) and the slide switches. Buttons get a one-cycle press
// pulse on an accepted falling level; switches get one shared change pulse.
module slc3_input_conditioner
  import slc3_io_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int SW_W      = 10
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Run_in,
  input  logic            Continue_in,
  input  logic [SW_W-1:0] SW_in,
  output logic            Run_db,
  output logic            Continue_db,
  output logic            Run_press,
  output logic            Continue_press,
  output logic [SW_W-1:0] SW_db,
  output logic            SW_change
);

  logic [SW_W-1:0] sw_rise, sw_fall;
  // Button releases are deliberately not reported.
  logic [1:0]      btn_rise_unused;

  debounce_bit #(.DB_CYCLES(DB_CYCLES), .RST_VAL(1'b1)) u_run (
    .Clk    (Clk),
    .Reset  (Reset),
    .in_raw (Run_in),
    .level  (Run_db),
    .rise   (btn_rise_unused[0]),
    .fall   (Run_press)
  );

  debounce_bit #(.DB_CYCLES(DB_CYCLES), .RST_VAL(1'b1)) u_cont (
    .Clk    (Clk),
    .Reset  (Reset),
    .in_raw (Continue_in),
    .level  (Continue_db),
    .rise   (btn_rise_unused[1]),
    .fall   (Continue_press)
  );

  for (genvar i = 0; i < SW_W; i++) begin : g_sw
    debounce_bit #(.DB_CYCLES(DB_CYCLES), .RST_VAL(1'b0)) u_sw (
      .Clk    (Clk),
      .Reset  (Reset),
      .in_raw (SW_in[i]),
      .level  (SW_db[i]),
      .rise   (sw_rise[i]),
      .fall   (sw_fall[i])
    );
  end

  // Edge flops share the db update edge, so several bits accepted together
  // merge into a single pulse aligned with the new SW_db value.
  assign SW_change = |{sw_rise, sw_fall};

endmodule

// File: tb/tb_slc3_input_conditioner.sv
// Bench for slc3_input_conditioner with DB_CYCLES = 4. Expected pulses are
// queued with their due cycle when stimulus is driven; a negedge monitor pops
// and compares them, and flags any unexpected pulse.
module tb_slc3_input_conditioner;

  localparam int DBC = 4;
  localparam int SWW = 10;
  localparam int LAT = DBC + 2;

  logic           Clk = 1'b0;
  logic           Reset;
  logic           Run_in, Continue_in;
  logic [SWW-1:0] SW_in;
  logic           Run_db, Continue_db, Run_press, Continue_press, SW_change;
  logic [SWW-1:0] SW_db;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  // kind: 0 = Run_press, 1 = Continue_press, 2 = SW_change (val = SW_db)
  typedef struct {
    int             kind;
    int             cyc;
    logic [SWW-1:0] val;
  } ev_t;
  ev_t exp_q[$];

  slc3_input_conditioner #(.DB_CYCLES(DBC), .SW_W(SWW)) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .Run_in         (Run_in),
    .Continue_in    (Continue_in),
    .SW_in          (SW_in),
    .Run_db         (Run_db),
    .Continue_db    (Continue_db),
    .Run_press      (Run_press),
    .Continue_press (Continue_press),
    .SW_db          (SW_db),
    .SW_change      (SW_change)
  );

  always #5 Clk = ~Clk;

  // Edge counter: at the negedge after edge N, cyc == N.
  always @(posedge Clk) cyc <= cyc + 1;

  // Scoreboard monitor.
  logic [2:0] mon_p;
  int         mon_idx;
  always @(negedge Clk) begin
    if (mon_en) begin
      mon_p = {SW_change, Continue_press, Run_press};
      for (int k = 0; k < 3; k++) begin
        mon_idx = -1;
        for (int i = 0; i < exp_q.size(); i++)
          if (mon_idx < 0 && exp_q[i].kind == k) mon_idx = i;
        if (mon_p[k] !== 1'b0 || (mon_idx >= 0 && exp_q[mon_idx].cyc <= cyc)) begin
          checks++;
          if (!(mon_p[k] === 1'b1 && mon_idx >= 0 && exp_q[mon_idx].cyc == cyc &&
                (k != 2 || SW_db === exp_q[mon_idx].val))) begin
            failures++;
            $display("FAIL pulse kind=%0d at cyc=%0d: got pulse=%b SW_db=%h, expected due cyc=%0d val=%h",
                     k, cyc, mon_p[k], SW_db,
                     (mon_idx >= 0) ? exp_q[mon_idx].cyc : -1,
                     (mon_idx >= 0) ? exp_q[mon_idx].val : '0);
          end
          if (mon_idx >= 0 && exp_q[mon_idx].cyc <= cyc) exp_q.delete(mon_idx);
        end
      end
    end
  end

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge Clk);
  endtask

  task automatic test_reset();
    Reset = 1'b0; Run_in = 1'b1; Continue_in = 1'b1; SW_in = '0;
    repeat (3) @(negedge Clk);
    checks++;
    if ({Run_db, Continue_db, Run_press, Continue_press, SW_change, SW_db} !== {5'b11000, 10'h000}) begin
      failures++;
      $display("FAIL reset_vals got=%b_%h required=11000_000",
               {Run_db, Continue_db, Run_press, Continue_press, SW_change}, SW_db);
    end
    mon_en = 1'b1;
    Reset  = 1'b1;
    repeat (20) @(negedge Clk);
    checks++;
    if ({Run_db, Continue_db, SW_db} !== {2'b11, 10'h000}) begin
      failures++;
      $display("FAIL idle_levels got=%b%b_%h required=11_000", Run_db, Continue_db, SW_db);
    end
  endtask

  task automatic check_empty(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s pending_events got=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_run_press();
    int k;
    Run_in = 1'b0; k = cyc + 1;
    exp_q.push_back('{0, k + LAT, '0});
    wait_to(k + LAT - 1);
    checks++;
    if (Run_db !== 1'b1) begin failures++; $display("FAIL run_early got=%b required=1", Run_db); end
    wait_to(k + LAT);
    checks++;
    if (Run_db !== 1'b0) begin failures++; $display("FAIL run_accept got=%b required=0", Run_db); end
    wait_to(k + LAT + 2);
    Run_in = 1'b1; k = cyc + 1;
    wait_to(k + LAT - 1);
    checks++;
    if (Run_db !== 1'b0) begin failures++; $display("FAIL run_rel_early got=%b required=0", Run_db); end
    wait_to(k + LAT);
    checks++;
    if (Run_db !== 1'b1) begin failures++; $display("FAIL run_release got=%b required=1", Run_db); end
    wait_to(k + LAT + 4);
    check_empty("run_press");
  endtask

  task automatic test_bounce();
    int k;
    Continue_in = 1'b0; @(negedge Clk);
    Continue_in = 1'b1; @(negedge Clk);
    Continue_in = 1'b0; @(negedge Clk);
    Continue_in = 1'b1; @(negedge Clk);
    Continue_in = 1'b0; k = cyc + 1;
    exp_q.push_back('{1, k + LAT, '0});
    wait_to(k + LAT - 1);
    checks++;
    if (Continue_db !== 1'b1) begin failures++; $display("FAIL bounce_early got=%b required=1", Continue_db); end
    wait_to(k + LAT);
    checks++;
    if (Continue_db !== 1'b0) begin failures++; $display("FAIL bounce_accept got=%b required=0", Continue_db); end
    wait_to(k + LAT + 2);
    Continue_in = 1'b1; k = cyc + 1;
    wait_to(k + LAT + 2);
    // 3-cycle low glitch must be rejected.
    Continue_in = 1'b0;
    repeat (3) @(negedge Clk);
    Continue_in = 1'b1;
    repeat (12) @(negedge Clk);
    checks++;
    if (Continue_db !== 1'b1) begin failures++; $display("FAIL glitch_level got=%b required=1", Continue_db); end
    check_empty("bounce");
  endtask

  task automatic test_switches();
    int k;
    SW_in = 10'h031; k = cyc + 1;
    exp_q.push_back('{2, k + LAT, 10'h031});
    wait_to(k + LAT + 2);
    SW_in = 10'h002; k = cyc + 1;
    exp_q.push_back('{2, k + LAT, 10'h002});
    wait_to(k + LAT - 1);
    checks++;
    if (SW_db !== 10'h031) begin failures++; $display("FAIL sw_early got=%h required=031", SW_db); end
    wait_to(k + LAT);
    checks++;
    if (SW_db !== 10'h002) begin failures++; $display("FAIL sw_accept got=%h required=002", SW_db); end
    wait_to(k + LAT + 2);
    check_empty("switches");
  endtask

  task automatic test_back_to_back();
    int k;
    SW_in = 10'h005; Continue_in = 1'b0; k = cyc + 1;
    exp_q.push_back('{2, k + LAT, 10'h005});
    exp_q.push_back('{1, k + LAT, '0});
    wait_to(k + LAT);
    checks++;
    if ({Continue_db, SW_db} !== {1'b0, 10'h005}) begin
      failures++;
      $display("FAIL simul_accept got=%b_%h required=0_005", Continue_db, SW_db);
    end
    wait_to(k + LAT + 2);
    Continue_in = 1'b1;
    repeat (LAT + 3) @(negedge Clk);
    checks++;
    if (Continue_db !== 1'b1) begin failures++; $display("FAIL simul_release got=%b required=1", Continue_db); end
    check_empty("back_to_back");
  endtask

  task automatic test_reset_pending();
    int k, k2;
    Run_in = 1'b0; k = cyc + 1;
    wait_to(k + 3);        // edge k+3 leaves cnt = 2
    Reset = 1'b0;
    @(negedge Clk); @(negedge Clk);
    checks++;
    if ({Run_db, Run_press, SW_db} !== {2'b10, 10'h000}) begin
      failures++;
      $display("FAIL rst_pending_hold got=%b%b_%h required=10_000", Run_db, Run_press, SW_db);
    end
    Reset = 1'b1; k2 = cyc + 1;
    exp_q.push_back('{0, k2 + LAT, '0});
    exp_q.push_back('{2, k2 + LAT, 10'h005});
    wait_to(k2 + LAT - 1);
    checks++;
    if ({Run_db, SW_db} !== {1'b1, 10'h000}) begin
      failures++;
      $display("FAIL rst_pending_early got=%b_%h required=1_000", Run_db, SW_db);
    end
    wait_to(k2 + LAT);
    checks++;
    if ({Run_db, SW_db} !== {1'b0, 10'h005}) begin
      failures++;
      $display("FAIL rst_pending_accept got=%b_%h required=0_005", Run_db, SW_db);
    end
    wait_to(k2 + LAT + 2);
    Run_in = 1'b1;
    repeat (LAT + 3) @(negedge Clk);
    check_empty("reset_pending");
  endtask

  task automatic test_sw_through_reset();
    int k, k2;
    SW_in = 10'h031; k = cyc + 1;
    exp_q.push_back('{2, k + LAT, 10'h031});
    wait_to(k + LAT + 2);
    Reset = 1'b0;
    @(negedge Clk); @(negedge Clk);
    checks++;
    if (SW_db !== 10'h000) begin failures++; $display("FAIL sw_in_reset got=%h required=000", SW_db); end
    Reset = 1'b1; k2 = cyc + 1;
    exp_q.push_back('{2, k2 + LAT, 10'h031});
    wait_to(k2 + LAT - 1);
    checks++;
    if (SW_db !== 10'h000) begin failures++; $display("FAIL sw_reacq_early got=%h required=000", SW_db); end
    wait_to(k2 + LAT);
    checks++;
    if (SW_db !== 10'h031) begin failures++; $display("FAIL sw_reacq got=%h required=031", SW_db); end
    wait_to(k2 + LAT + 4);
    check_empty("sw_through_reset");
  endtask

  initial begin
    test_reset();
    test_run_press();
    test_bounce();
    test_switches();
    test_back_to_back();
    test_reset_pending();
    test_sw_through_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
